// File: rtl/sha_pkg.sv
// Shared SHA-256 definitions: word type, round constants, IV, FSM states
// and the six bitwise mixing functions used by the round and schedule logic.
package sha_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Working variables; a sits in the MSBs so a 256-bit H0..H7 vector casts directly.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha_compress_iter_if.sv
// Block-in / digest-out handshake bundle for the iterative compression core.
interface sha_compress_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] state_in;
  logic [511:0] block_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest_out;
  logic         busy;

  modport master (
    output in_valid, state_in, block_in, out_ready,
    input  in_ready, out_valid, digest_out, busy
  );

  modport slave (
    input  in_valid, state_in, block_in, out_ready,
    output in_ready, out_valid, digest_out, busy
  );
endinterface

// File: rtl/sha_round_step.sv
// One combinational SHA-256 round: a..h plus K_t and W_t in, next a..h out.
module sha_round_step
  import sha_pkg::*;
(
  input  work_t cur,
  input  word_t k,
  input  word_t w,
  output work_t nxt
);

  word_t t1;
  word_t t2;

  // Round function with modular 32-bit sums.
  always_comb begin
    t1  = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    t2  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
            e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};
  end

endmodule

// File: rtl/sha_compress_iter.sv
// Iterative SHA-256 compression core, UNROLL rounds per clock.
// Build option SHA_FEEDFWD_EN: when defined, an ADD state adds the saved
// chaining value to the final a..h; otherwise raw a..h is returned one
// cycle earlier.
module sha_compress_iter
  import sha_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input logic               clk,
  input logic               reset,
  sha_compress_iter_if.slave bus
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha_compress_iter: UNROLL must be 1, 2, 4 or 8");
  end

  state_t       state;
  state_t       state_nxt;
  logic [5:0]   t;
  work_t        work;
  word_t        win [16];
  word_t        ext [16+UNROLL];
  logic [255:0] digest;
  logic         last_round;
  logic         accept;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  work_t        rounds_out;
`ifdef SHA_FEEDFWD_EN
  work_t        saved;
`endif

  assign last_round = ({1'b0, t} + 7'(UNROLL)) == 7'd64;
  assign accept     = in_ready & bus.in_valid;

  // Window holds W_t..W_t+15; the UNROLL words beyond it are expanded here,
  // later ones chaining on earlier ones within the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) ext[i] = win[i];
    for (int unsigned k = 0; k < UNROLL; k++) begin
      ext[16+k] = small_sigma1(ext[14+k]) + ext[9+k] + small_sigma0(ext[1+k]) + ext[k];
    end
  end

  // Chain of UNROLL round steps; each stage reads the previous stage's output.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    work_t cur;
    work_t nxt;
    if (j == 0) begin : g_first
      assign cur = work;
    end else begin : g_next
      assign cur = g_rnd[j-1].nxt;
    end
    sha_round_step u_step (
      .cur (cur),
      .k   (K[t + 6'(j)]),
      .w   (ext[j]),
      .nxt (nxt)
    );
  end

  assign rounds_out = g_rnd[UNROLL-1].nxt;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~reset;
        if (bus.in_valid && !reset) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_round) begin
`ifdef SHA_FEEDFWD_EN
          state_nxt = ADD;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef SHA_FEEDFWD_EN
      ADD: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working variables, schedule window, round counter and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t      <= '0;
      work   <= '0;
      win    <= '{default: '0};
      digest <= '0;
`ifdef SHA_FEEDFWD_EN
      saved  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work <= work_t'(bus.state_in);
`ifdef SHA_FEEDFWD_EN
            saved <= work_t'(bus.state_in);
`endif
            for (int unsigned i = 0; i < 16; i++) win[i] <= bus.block_in[511-32*i -: 32];
            t <= '0;
          end
        end
        RUN: begin
          work <= rounds_out;
          t    <= t + 6'(UNROLL);
          for (int unsigned i = 0; i < 16; i++) win[i] <= ext[i+UNROLL];
`ifndef SHA_FEEDFWD_EN
          if (last_round) digest <= rounds_out;
`endif
        end
`ifdef SHA_FEEDFWD_EN
        ADD: begin
          digest <= {saved.a + work.a, saved.b + work.b, saved.c + work.c, saved.d + work.d,
                     saved.e + work.e, saved.f + work.f, saved.g + work.g, saved.h + work.h};
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = busy;
  assign bus.digest_out = digest;

endmodule

// File: tb/tb_sha_compress_iter.sv
// Bench for sha_compress_iter: four instances (UNROLL 1/2/4/8) checked against
// known SHA-256 vectors and an array-based compression model.
module tb_sha_compress_iter;

`ifdef SHA_FEEDFWD_EN
  localparam int FF_EXTRA = 1;
  localparam bit FF       = 1'b1;
`else
  localparam int FF_EXTRA = 0;
  localparam bit FF       = 1'b0;
`endif

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid  [4];
  logic [255:0] state_in  [4];
  logic [511:0] block_in  [4];
  logic         out_ready [4];
  logic         in_ready  [4];
  logic         out_valid [4];
  logic         busy      [4];
  logic [255:0] digest    [4];

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  always #5 clk = ~clk;

  sha_compress_iter_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha_compress_iter #(.UNROLL(1 << g)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );
    assign bus[g].in_valid  = in_valid[g];
    assign bus[g].state_in  = state_in[g];
    assign bus[g].block_in  = block_in[g];
    assign bus[g].out_ready = out_ready[g];
    assign in_ready[g]      = bus[g].in_ready;
    assign out_valid[g]     = bus[g].out_valid;
    assign busy[g]          = bus[g].busy;
    assign digest[g]        = bus[g].digest_out;
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression: full 64-word schedule, then 64 rounds over v[0..7].
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk, input bit ff);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  h0 [8];
    logic [31:0]  t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) begin
      h0[i] = hin[255-32*i -: 32];
      v[i]  = h0[i];
    end
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = ff ? (h0[i] + v[i]) : v[i];
    return res;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present a block and return at the negedge following its acceptance edge.
  task automatic start_block(input int idx, input logic [255:0] st, input logic [511:0] blk, input string tag);
    int guard = 0;
    @(negedge clk);
    in_valid[idx] = 1'b1;
    state_in[idx] = st;
    block_in[idx] = blk;
    while (!in_ready[idx] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " accept"}, 256'(in_ready[idx]), 256'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count edges from acceptance until out_valid is seen (bounded).
  task automatic wait_out(input int idx, input string tag, output int lat);
    lat = 0;
    check({tag, " busy"}, 256'(busy[idx]), 256'd1);
    while (!out_valid[idx] && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic finish_out(input int idx, input string tag);
    out_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid cleared"}, 256'(out_valid[idx]), 256'd0);
    check({tag, " in_ready after handshake"}, 256'(in_ready[idx]), 256'd1);
  endtask

  task automatic do_block(input int idx, input logic [255:0] st, input logic [511:0] blk,
                          input logic [255:0] exp, input string tag);
    int lat;
    start_block(idx, st, blk, tag);
    in_valid[idx] = 1'b0;
    wait_out(idx, tag, lat);
    check({tag, " latency"}, 256'(lat), 256'((64 >> idx) + FF_EXTRA));
    check({tag, " digest"}, digest[idx], exp);
    check({tag, " in_ready in DONE"}, 256'(in_ready[idx]), 256'd0);
    finish_out(idx, tag);
  endtask

  function automatic logic [255:0] rand_state();
    logic [255:0] s = '0;
    for (int k = 0; k < 8; k++) s = {s[223:0], 32'($urandom())};
    return s;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b = '0;
    for (int k = 0; k < 16; k++) b = {b[479:0], 32'($urandom())};
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] exp_abc, exp_empty, s1, s2, e1, e2;
    logic [511:0] b1, b2;
    int lat;

    exp_abc   = FF ? DIG_ABC   : ref_compress(H_IV, BLK_ABC, 1'b0);
    exp_empty = FF ? DIG_EMPTY : ref_compress(H_IV, BLK_EMPTY, 1'b0);

    reset = 1'b1;
    for (int g = 0; g < 4; g++) begin
      in_valid[g]  = 1'b0;
      state_in[g]  = '0;
      block_in[g]  = '0;
      out_ready[g] = 1'b1;
    end

    // Reset values on every instance.
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rst in_ready u%0d", g), 256'(in_ready[g]), 256'd0);
      check($sformatf("rst out_valid u%0d", g), 256'(out_valid[g]), 256'd0);
      check($sformatf("rst busy u%0d", g), 256'(busy[g]), 256'd0);
      check($sformatf("rst digest u%0d", g), digest[g], 256'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++)
      check($sformatf("idle in_ready u%0d", g), 256'(in_ready[g]), 256'd1);

    // Known vectors.
    do_block(0, H_IV, BLK_ABC, exp_abc, "abc u1");
    for (int g = 1; g < 4; g++)
      do_block(g, H_IV, BLK_EMPTY, exp_empty, $sformatf("empty u%0d", 1 << g));

    // Random chaining values and blocks against the model.
    for (int r = 0; r < 3; r++) begin
      for (int g = 0; g < 4; g++) begin
        s1 = rand_state();
        b1 = rand_block();
        do_block(g, s1, b1, ref_compress(s1, b1, FF), $sformatf("rand%0d u%0d", r, 1 << g));
      end
    end

    // Back-pressure with in_valid held high across two blocks.
    s1 = rand_state(); b1 = rand_block(); e1 = ref_compress(s1, b1, FF);
    s2 = rand_state(); b2 = rand_block(); e2 = ref_compress(s2, b2, FF);
    out_ready[0] = 1'b0;
    start_block(0, s1, b1, "b2b first");
    state_in[0] = s2;
    block_in[0] = b2;
    wait_out(0, "b2b first", lat);
    check("b2b first latency", 256'(lat), 256'(64 + FF_EXTRA));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d digest", c), digest[0], e1);
      check($sformatf("hold%0d out_valid", c), 256'(out_valid[0]), 256'd1);
      check($sformatf("hold%0d in_ready", c), 256'(in_ready[0]), 256'd0);
    end
    finish_out(0, "b2b first");
    out_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    wait_out(0, "b2b second", lat);
    check("b2b second latency", 256'(lat), 256'(64 + FF_EXTRA));
    check("b2b second digest", digest[0], e2);
    finish_out(0, "b2b second");

    // Asynchronous reset in the middle of round processing.
    start_block(0, H_IV, BLK_ABC, "midreset");
    in_valid[0] = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset out_valid", 256'(out_valid[0]), 256'd0);
    check("midreset busy", 256'(busy[0]), 256'd0);
    check("midreset in_ready", 256'(in_ready[0]), 256'd0);
    check("midreset digest", digest[0], 256'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_block(0, H_IV, BLK_ABC, exp_abc, "abc after reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
